alu_seq: RTL and testbench
==========================

# alu_seq

Sequential, parametrised-width ALU with valid/ready handshakes on operand input and result output. It executes the 5-bit opcode set used by the datapath: move, add, subtract, and, xor, lowest-differing-bit index, and logical/arithmetic shifts. Shifts run iteratively, one bit per cycle, unless the barrel option is compiled in. It sits between the register-read stage and writeback, and back-pressures the issue logic while busy.

## Interface
- `WIDTH`, default 32: operand and result width, must be ≥ 4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount and index width. Derived; not overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  operands and opcode are presented.
- `in_ready`  out  1  block accepts a new operation.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B; the shift amount is `b[SHW-1:0]`.
- `op`  in  5  opcode.
- `out_valid`  out  1  result is available.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  operation result.
- `carry`  out  1  carry/no-borrow flag.
- `zero`  out  1  high when `result == 0`.
- `illegal`  out  1  the opcode was unrecognised.

## Operation
- **Opcodes:**
  - `00000` MOVE: result = A.
  - `00001` ADD: A+B.
  - `00010` SUB: A+~B+1.
  - `00011` AND.
  - `00100` XOR.
  - `00101` DIFF: index of the lowest set bit of A^B; all-ones if A==B.
  - `01000` SRL, `01001` SRA, `01010` SLL.
  - Any other opcode: result 0, `illegal`=1.
- **Flags:**
  - `carry` = carry-out of bit WIDTH-1 for ADD and SUB (SUB: 1 means no borrow). `carry` = 0 for all other ops.
  - `zero` is computed from the final result.
- **FSM states:** IDLE, SHIFT, DONE.
  - IDLE: `in_ready`=1. Accept on `in_valid`, which latches a, b and op.
    - Shift op with nonzero amount → SHIFT. The shift counter is loaded with the amount; the working register is loaded with A.
    - Any other op, or a shift of 0 → DONE, result registered.
  - SHIFT: each cycle shift the working register by 1 and decrement the counter.
    - SRA replicates the MSB; SRL and SLL fill with 0.
    - Counter reaching 0 → DONE.
  - DONE: `out_valid`=1, outputs stable. On `out_ready` → IDLE.
- `in_ready` is high only in IDLE. There is no accept in the same cycle that the result is consumed.
- Shift amounts ≥ WIDTH cannot occur, because only `b[SHW-1:0]` is used.
- Reset at any point abandons the in-flight operation.

## Timing
- Reset values:
  - state IDLE, `in_ready`=1.
  - `out_valid`=0, `result`=0, `carry`=0, `zero`=0, `illegal`=0.
- Latency from the accept edge to `out_valid` high:
  - Non-shift ops: 1 cycle.
  - Shifts: 1 + amount cycles.
- `result`, `carry`, `zero` and `illegal` are registered. They change only on entry to DONE.
- Throughput: at most one op per 2 cycles. Each IDLE→DONE→IDLE round trip is ≥ 2 cycles.
- `out_ready` held high in DONE: the result is consumed on that edge and the block returns to IDLE.
- `out_ready` asserted outside DONE is ignored.
- `in_valid` outside IDLE is ignored. The source must hold its operands until `in_ready`.

## Configuration
- `ALU_SEQ_BARREL_EN`:
  - Defined: a combinational barrel shifter is used. Shifts go IDLE→DONE with latency 1, and the SHIFT state is unreachable.
  - Undefined: shifts are iterative as described under Operation.
- Results are identical in both builds; only latency differs.

## Structure
- Package `alu_seq_pkg` holds:
  - Opcode localparams: `OP_MOVE`, `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_XOR`, `OP_DIFF`, `OP_SRL`, `OP_SRA`, `OP_SLL`.
  - The state encoding typedef.
- Sub-module `alu_seq_shifter`, parametrised by WIDTH:
  - Provides the single-step shift when iterative.
  - Provides the full barrel shift when `ALU_SEQ_BARREL_EN` is defined.
- The top level holds the FSM, counter, adder and DIFF priority encoder.

## Test plan
- Reset then idle: `in_ready`=1, `out_valid`=0, result 0. Assert `rst` while in SHIFT → IDLE next cycle, `out_valid`=0.
- ADD 0xFFFFFFFF + 1 → result 0, `carry`=1, `zero`=1, `out_valid` 1 cycle after accept. SUB 5−7 → 0xFFFFFFFE, `carry`=0.
- SRA a=0x80000000, b=4 → 0xF8000000 after 5 cycles. Same op with `ALU_SEQ_BARREL_EN` → after 1 cycle. SLL with b=0 → A unchanged, latency 1.
- DIFF a=0x0000_00F0, b=0x0000_0070 → 7. DIFF with a==b → 0xFFFFFFFF.
- Back-pressure: hold `out_ready`=0 for 10 cycles in DONE → outputs stable, `in_ready`=0, `in_valid` ignored. Then release → IDLE.
- Opcode `11111` → result 0, `illegal`=1. The next legal op clears `illegal`.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Opcode constants, FSM state encoding and flag bundle for alu_seq.
package alu_seq_pkg;

  localparam logic [4:0] OP_MOVE = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_DIFF = 5'b00101;
  localparam logic [4:0] OP_SRL  = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01001;
  localparam logic [4:0] OP_SLL  = 5'b01010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic illegal;
  } flags_t;

  function automatic logic is_shift(input logic [4:0] op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Shift unit: one-bit step (default) or full barrel shift when ALU_SEQ_BARREL_EN is defined.
// Purely combinational; kind = op[1:0] (00 SRL, 01 SRA, 10 SLL).
module alu_seq_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
`ifdef ALU_SEQ_BARREL_EN
  input  logic [SHW-1:0]   amt,
`endif
  input  logic [1:0]       kind,
  output logic [WIDTH-1:0] dout
);

`ifdef ALU_SEQ_BARREL_EN
  always_comb begin
    dout = din >> amt;
    case (kind)
      2'b01:   dout = $signed(din) >>> amt;
      2'b10:   dout = din << amt;
      default: dout = din >> amt;
    endcase
  end
`else
  always_comb begin
    dout = {1'b0, din[WIDTH-1:1]};
    case (kind)
      2'b01:   dout = {din[WIDTH-1], din[WIDTH-1:1]};
      2'b10:   dout = {din[WIDTH-2:0], 1'b0};
      default: dout = {1'b0, din[WIDTH-1:1]};
    endcase
  end
`endif

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes; ALU_SEQ_BARREL_EN selects single-cycle shifts.
// Latency: 1 cycle, or 1 + shift amount for iterative shifts.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             illegal
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;

  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] b_eff, xab, diff_res, alu_res, shf_out, shf_res;
  logic [WIDTH:0]   sum;
  logic             alu_carry, alu_illegal;
  logic             accept, go_shift, shift_last;

  assign amt    = b[SHW-1:0];
  assign accept = (state_q == ST_IDLE) && in_valid;

`ifdef ALU_SEQ_BARREL_EN
  alu_seq_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .din  (a),
    .amt  (amt),
    .kind (op[1:0]),
    .dout (shf_out)
  );
  assign shf_res    = shf_out;
  assign go_shift   = 1'b0;
  assign shift_last = 1'b1;
`else
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic [1:0]       kind_q;

  alu_seq_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .din  (work_q),
    .kind (kind_q),
    .dout (shf_out)
  );
  // A zero-amount shift is a plain move of A.
  assign shf_res    = a;
  assign go_shift   = is_shift(op) && (amt != '0);
  assign shift_last = (cnt_q == SHW'(1));
`endif

  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
  assign xab   = a ^ b;

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    diff_res = '1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (xab[i]) diff_res = WIDTH'(i);
    end
  end

  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    case (op)
      OP_MOVE:                alu_res = a;
      OP_ADD, OP_SUB:         {alu_carry, alu_res} = sum;
      OP_AND:                 alu_res = a & b;
      OP_XOR:                 alu_res = xab;
      OP_DIFF:                alu_res = diff_res;
      OP_SRL, OP_SRA, OP_SLL: alu_res = shf_res;
      default:                alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = go_shift ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (shift_last) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
`ifndef ALU_SEQ_BARREL_EN
      work_q   <= '0;
      cnt_q    <= '0;
      kind_q   <= '0;
`endif
    end else begin
`ifndef ALU_SEQ_BARREL_EN
      if (accept && go_shift) begin
        work_q <= a;
        cnt_q  <= amt;
        kind_q <= op[1:0];
      end
      if (state_q == ST_SHIFT) begin
        work_q <= shf_out;
        cnt_q  <= cnt_q - SHW'(1);
        if (shift_last) begin
          result_q <= shf_out;
          flags_q  <= flags_t'{carry: 1'b0, zero: (shf_out == '0), illegal: 1'b0};
        end
      end
`endif
      if (accept && !go_shift) begin
        result_q <= alu_res;
        flags_q  <= flags_t'{carry: alu_carry, zero: (alu_res == '0), illegal: alu_illegal};
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign illegal   = flags_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq; expected latencies follow ALU_SEQ_BARREL_EN.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        carry, zero, illegal;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic int shlat(input int amt);
`ifdef ALU_SEQ_BARREL_EN
    return 1;
`else
    return (amt == 0) ? 1 : 1 + amt;
`endif
  endfunction

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [4:0] iop);
    @(negedge clk);
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 ||
        carry !== 1'b0 || zero !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b res=%h c=%b z=%b ill=%b, want 1 0 0 0 0 0",
               in_ready, out_valid, result, carry, zero, illegal);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_arith();
    int lat;
    issue(32'hFFFF_FFFF, 32'h1, 5'b00001);
    wait_done(lat);
    checks++;
    if (result !== 32'h0 || carry !== 1'b1 || zero !== 1'b1 || illegal !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL add_wrap: res=%h c=%b z=%b ill=%b lat=%0d, want 0 1 1 0 1", result, carry, zero, illegal, lat);
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL consume: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
    issue(32'd5, 32'd7, 5'b00010);
    wait_done(lat);
    checks++;
    if (result !== 32'hFFFF_FFFE || carry !== 1'b0 || zero !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL sub_borrow: res=%h c=%b z=%b lat=%0d, want fffffffe 0 0 1", result, carry, zero, lat);
    end
    consume();
    issue(32'd7, 32'd5, 5'b00010);
    wait_done(lat);
    checks++;
    if (result !== 32'd2 || carry !== 1'b1) begin
      errors++;
      $display("FAIL sub_noborrow: res=%h c=%b, want 00000002 1", result, carry);
    end
    consume();
    issue(32'hF0F0_1234, 32'h0FF0_FFFF, 5'b00011);
    wait_done(lat);
    checks++;
    if (result !== 32'h00F0_1234 || carry !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL and: res=%h c=%b lat=%0d, want 00f01234 0 1", result, carry, lat);
    end
    consume();
    issue(32'h0, 32'h1234_5678, 5'b00000);
    wait_done(lat);
    checks++;
    if (result !== 32'h0 || zero !== 1'b1 || lat != 1) begin
      errors++;
      $display("FAIL move_zero: res=%h z=%b lat=%0d, want 0 1 1", result, zero, lat);
    end
    consume();
  endtask

  task automatic test_shift();
    int lat;
    issue(32'h8000_0000, 32'd4, 5'b01001);
    wait_done(lat);
    checks++;
    if (result !== 32'hF800_0000 || carry !== 1'b0 || lat != shlat(4)) begin
      errors++;
      $display("FAIL sra4: res=%h c=%b lat=%0d, want f8000000 0 %0d", result, carry, lat, shlat(4));
    end
    consume();
    issue(32'h0000_1234, 32'd0, 5'b01010);
    wait_done(lat);
    checks++;
    if (result !== 32'h0000_1234 || lat != 1) begin
      errors++;
      $display("FAIL sll0: res=%h lat=%0d, want 00001234 1", result, lat);
    end
    consume();
    issue(32'hF000_00F0, 32'hFFFF_FFE4, 5'b01000);
    wait_done(lat);
    checks++;
    if (result !== 32'h0F00_000F || lat != shlat(4)) begin
      errors++;
      $display("FAIL srl4_masked: res=%h lat=%0d, want 0f00000f %0d", result, lat, shlat(4));
    end
    consume();
    issue(32'h0000_0003, 32'd31, 5'b01010);
    wait_done(lat);
    checks++;
    if (result !== 32'h8000_0000 || zero !== 1'b0 || lat != shlat(31)) begin
      errors++;
      $display("FAIL sll31: res=%h z=%b lat=%0d, want 80000000 0 %0d", result, zero, lat, shlat(31));
    end
    consume();
    issue(32'h8000_0000, 32'd31, 5'b01000);
    wait_done(lat);
    checks++;
    if (result !== 32'h0000_0001 || lat != shlat(31)) begin
      errors++;
      $display("FAIL srl31: res=%h lat=%0d, want 00000001 %0d", result, lat, shlat(31));
    end
    consume();
  endtask

  task automatic test_diff();
    int lat;
    issue(32'h0000_00F0, 32'h0000_0070, 5'b00101);
    wait_done(lat);
    checks++;
    if (result !== 32'd7 || lat != 1) begin
      errors++;
      $display("FAIL diff7: res=%h lat=%0d, want 00000007 1", result, lat);
    end
    consume();
    issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'b00101);
    wait_done(lat);
    checks++;
    if (result !== 32'hFFFF_FFFF || zero !== 1'b0) begin
      errors++;
      $display("FAIL diff_eq: res=%h z=%b, want ffffffff 0", result, zero);
    end
    consume();
    issue(32'h8000_0001, 32'h0000_0000, 5'b00101);
    wait_done(lat);
    checks++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL diff0: res=%h z=%b, want 00000000 1", result, zero);
    end
    consume();
  endtask

  task automatic test_back_pressure();
    int lat;
    int bad = 0;
    issue(32'hF0F0_F0F0, 32'hFFFF_0000, 5'b00100);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'h1; b = 32'h1; op = 5'b00001;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h0F0F_F0F0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold: %0d bad cycles, vld=%b rdy=%b res=%h, want 1 0 0f0ff0f0", bad, out_valid, in_ready, result);
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0F0F_F0F0) begin
      errors++;
      $display("FAIL release: rdy=%b vld=%b res=%h, want 1 0 0f0ff0f0", in_ready, out_valid, result);
    end
  endtask

  task automatic test_illegal();
    int lat;
    issue(32'h1234_5678, 32'h1, 5'b11111);
    wait_done(lat);
    checks++;
    if (result !== 32'h0 || illegal !== 1'b1 || zero !== 1'b1 || carry !== 1'b0) begin
      errors++;
      $display("FAIL illegal: res=%h ill=%b z=%b c=%b, want 0 1 1 0", result, illegal, zero, carry);
    end
    consume();
    issue(32'h5, 32'h0, 5'b00000);
    wait_done(lat);
    checks++;
    if (result !== 32'h5 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: res=%h ill=%b, want 00000005 0", result, illegal);
    end
    consume();
    issue(32'h5, 32'h3, 5'b00110);
    wait_done(lat);
    checks++;
    if (result !== 32'h0 || illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_gap: res=%h ill=%b, want 0 1", result, illegal);
    end
    consume();
  endtask

  task automatic test_reset_in_shift();
    issue(32'hFFFF_FFFF, 32'd20, 5'b01000);
    repeat (3) @(posedge clk);
    #1 checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy: rdy=%b, want 0", in_ready);
    end
    rst = 1'b1;
    #1 checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL rst_shift: rdy=%b vld=%b res=%h ill=%b, want 1 0 0 0", in_ready, out_valid, result, illegal);
    end
    @(negedge clk) rst = 1'b0;
    repeat (25) @(posedge clk);
    #1 checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_abandon: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_diff();
    test_back_pressure();
    test_illegal();
    test_reset_in_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
